// File: rtl/dds_pkg.sv
// Shared definitions for the AD9764 DDS transmitter: default widths, DAC code constants, FSM encoding.
// No logic of its own; the sine helper is evaluated only at elaboration to build the ROM contents.
// No flow control.
package dds_pkg;

    localparam int DDS_PHASE_W = 32;
    localparam int DDS_LUT_AW  = 8;
    localparam int DDS_DAC_W   = 14;
    localparam int DDS_AMP_W   = 8;
    localparam int DDS_BURST_W = 16;

    // Inverted offset binary code for 0 V out of the DAC
    localparam logic [13:0] DAC_MID_INV = 14'h1FFF;

    // Cycles spent flushing the sample pipeline after the last sample enters it
    localparam int DRAIN_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dds_state_t;

    // Quarter-wave entry idx: round((2^mag_w - 1) * sin(pi/2 * idx / 2^aw))
    function automatic int sine_entry(input int idx, input int aw, input int mag_w);
        real ang;
        real full;
        ang  = 1.5707963267948966 * real'(idx) / real'(2 ** aw);
        full = real'((2 ** mag_w) - 1) * $sin(ang);
        return $rtoi(full + 0.5);
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude ROM, contents fixed at elaboration.
// Latency 1 cycle (registered read).
// No flow control; a new address is accepted every cycle.
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int AW = DDS_LUT_AW,
    parameter int DW = DDS_DAC_W - 1
) (
    input  logic          CLK,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] mag_o
);

    logic [DW-1:0] rom [0:(2**AW)-1];

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        localparam logic [DW-1:0] ENTRY = DW'(sine_entry(i, AW, DW));
        assign rom[i] = ENTRY;
    end

    // Registered table lookup
    always_ff @(posedge CLK) begin
        mag_o <= rom[addr_i];
    end

endmodule

// File: rtl/ad9764_dds_tx.sv
// DDS sine-burst generator driving an AD9764 DAC port (inverted offset binary).
// Latency 4 cycles from phase register to DA_out.
// cfg_ready is always high (shadowed config); samples are never stalled.
module ad9764_dds_tx
    import dds_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int LUT_AW  = DDS_LUT_AW,
    parameter int DAC_W   = DDS_DAC_W,
    parameter int AMP_W   = DDS_AMP_W,
    parameter int BURST_W = DDS_BURST_W
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fword,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               sample_valid,
    output logic [DAC_W-1:0]   DA_out,
    output logic               DA_CLK
);

    localparam int MAG_W    = DAC_W - 1;
    localparam int PROD_W   = DAC_W + AMP_W + 1;
    localparam int DRAIN_CW = $clog2(DRAIN_CYCLES);
    localparam logic [DAC_W-1:0] MID_CODE  = {1'b0, {(DAC_W-1){1'b1}}};
    localparam logic [DAC_W-1:0] SIGN_CODE = {1'b1, {(DAC_W-1){1'b0}}};

    // Configuration: shadow (written on accept) and active (used by the datapath)
    logic [PHASE_W-1:0] shd_fword_q, act_fword_q;
    logic [AMP_W-1:0]   shd_amp_q,   act_amp_q;
    logic [BURST_W-1:0] shd_burst_q, act_burst_q;

    // Control
    dds_state_t         state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W:0]   phase_sum;
    logic [BURST_W-1:0] cnt_q;
    logic [DRAIN_CW-1:0] drain_q;
    logic               busy_q, done_q;

    // Pipeline
    logic [1:0]         s1_quad_d;
    logic [LUT_AW-1:0]  s1_addr_d;
    logic [LUT_AW-1:0]  s1_addr_q;
    logic               s1_vld_q, s1_neg_q;
    logic [AMP_W-1:0]   s1_amp_q;
    logic [MAG_W-1:0]   s2_mag;
    logic               s2_vld_q, s2_neg_q;
    logic [AMP_W-1:0]   s2_amp_q;
    logic signed [DAC_W-1:0]  s3_mag_ext, s3_s_d;
    logic signed [PROD_W-1:0] s3_s_ext, s3_amp_ext, s3_prod;
    logic [DAC_W-1:0]   s3_p_d, s3_p_q;
    logic               s3_vld_q;
    logic [DAC_W-1:0]   s4_da_q;
    logic               s4_vld_q;

    assign cfg_ready = 1'b1;
    assign DA_CLK    = CLK;
    assign phase_sum = {1'b0, phase_q} + {1'b0, act_fword_q};

    // Capture every accepted configuration into the shadow register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            shd_fword_q <= '0;
            shd_amp_q   <= '0;
            shd_burst_q <= '0;
        end else if (cfg_valid && cfg_ready) begin
            shd_fword_q <= cfg_fword;
            shd_amp_q   <= cfg_amp;
            shd_burst_q <= cfg_burst;
        end
    end

    // Burst FSM, phase accumulator, burst/drain counters and shadow->active promotion
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            act_fword_q <= '0;
            act_amp_q   <= '0;
            act_burst_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    act_fword_q <= shd_fword_q;
                    act_amp_q   <= shd_amp_q;
                    act_burst_q <= shd_burst_q;
                    // stop in the same cycle cancels the start
                    if (start && !stop) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        phase_q <= '0;
                        cnt_q   <= act_burst_q;
                    end
                end
                RUN: begin
                    phase_q <= phase_sum[PHASE_W-1:0];
                    // Promote new config only at the accumulator wrap so the phase stays continuous
                    if (phase_sum[PHASE_W]) begin
                        act_fword_q <= shd_fword_q;
                        act_amp_q   <= shd_amp_q;
                        act_burst_q <= shd_burst_q;
                    end
                    // A zero count means continuous: never decremented
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - BURST_W'(1);
                    end
                    if (stop || (cnt_q == BURST_W'(1))) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_CW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // S1 address fold: odd quadrants read the quarter table backwards
    always_comb begin
        s1_quad_d = phase_q[PHASE_W-1 -: 2];
        s1_addr_d = phase_q[PHASE_W-3 -: LUT_AW];
        if (s1_quad_d[0]) begin
            s1_addr_d = ~s1_addr_d;
        end
    end

    // S1 register; amplitude travels with its sample so a mid-burst change never splits one
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s1_vld_q  <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_amp_q  <= '0;
        end else begin
            s1_vld_q  <= (state_q == RUN);
            s1_neg_q  <= s1_quad_d[1];
            s1_addr_q <= s1_addr_d;
            s1_amp_q  <= act_amp_q;
        end
    end

    // S2 magnitude lookup
    sine_quarter_rom #(
        .AW (LUT_AW),
        .DW (MAG_W)
    ) u_rom (
        .CLK    (CLK),
        .addr_i (s1_addr_q),
        .mag_o  (s2_mag)
    );

    // S2 side-band alignment with the ROM output
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s2_vld_q <= 1'b0;
            s2_neg_q <= 1'b0;
            s2_amp_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_neg_q <= s1_neg_q;
            s2_amp_q <= s1_amp_q;
        end
    end

    // S3 sign restore and amplitude scale; arithmetic shift rounds toward minus infinity
    always_comb begin
        s3_mag_ext = {1'b0, s2_mag};
        s3_s_d     = s2_neg_q ? -s3_mag_ext : s3_mag_ext;
        s3_s_ext   = {{(PROD_W-DAC_W){s3_s_d[DAC_W-1]}}, s3_s_d};
        s3_amp_ext = {{(PROD_W-AMP_W){1'b0}}, s2_amp_q};
        s3_prod    = s3_s_ext * s3_amp_ext;
        s3_p_d     = DAC_W'(s3_prod >>> AMP_W);
    end

    // S3 register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s3_vld_q <= 1'b0;
            s3_p_q   <= '0;
        end else begin
            s3_vld_q <= s2_vld_q;
            s3_p_q   <= s3_p_d;
        end
    end

    // S4 two's complement -> inverted offset binary, parked at midscale when idle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            s4_vld_q <= 1'b0;
            s4_da_q  <= MID_CODE;
        end else begin
            s4_vld_q <= s3_vld_q;
            s4_da_q  <= s3_vld_q ? ~(s3_p_q ^ SIGN_CODE) : MID_CODE;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = s4_vld_q;
    assign DA_out       = s4_da_q;

endmodule

// File: tb/tb_ad9764_dds_tx.sv
module tb_ad9764_dds_tx;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_fword;
    logic [7:0]  cfg_amp;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        sample_valid;
    logic [13:0] DA_out;
    logic        DA_CLK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [13:0] exp_q[$];
    logic [13:0] exp_v;

    // Bench model of the active configuration and phase
    logic [31:0] m_phase;
    logic [31:0] m_act_fw;
    logic [31:0] m_shd_fw;
    logic [7:0]  m_amp;

    always #5 CLK = ~CLK;

    ad9764_dds_tx dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_fword    (cfg_fword),
        .cfg_amp      (cfg_amp),
        .cfg_burst    (cfg_burst),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .sample_valid (sample_valid),
        .DA_out       (DA_out),
        .DA_CLK       (DA_CLK)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [13:0] model_sample(input logic [31:0] ph, input logic [7:0] amp);
        logic [1:0]  q;
        logic [7:0]  a;
        int          mag;
        int          s;
        int          p;
        logic [13:0] pv;
        q = ph[31:30];
        a = ph[29:22];
        if (q[0]) a = ~a;
        mag = $rtoi(8191.0 * $sin(3.14159265358979 / 2.0 * real'(a) / 256.0) + 0.5);
        s   = q[1] ? -mag : mag;
        p   = (s * int'(amp)) >>> 8;
        pv  = p[13:0];
        return ~(pv ^ 14'h2000);
    endfunction

    // One RUN cycle of the model; cfg_now marks a cfg accepted in that same cycle
    task automatic model_step(input bit cfg_now, input logic [31:0] cfg_fw);
        logic [32:0] sum;
        exp_q.push_back(model_sample(m_phase, m_amp));
        sum     = {1'b0, m_phase} + {1'b0, m_act_fw};
        m_phase = sum[31:0];
        if (sum[32]) m_act_fw = m_shd_fw;
        if (cfg_now) m_shd_fw = cfg_fw;
    endtask

    task automatic do_cfg(input logic [31:0] fw, input logic [7:0] amp, input logic [15:0] burst);
        cfg_valid = 1'b1;
        cfg_fword = fw;
        cfg_amp   = amp;
        cfg_burst = burst;
        step();
        cfg_valid = 1'b0;
        step();
        m_shd_fw = fw;
        m_act_fw = fw;
        m_amp    = amp;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start   = 1'b0;
        m_phase = '0;
    endtask

    // Called right after the edge that moved RUN -> DRAIN
    task automatic drain_check(input string tag);
        repeat (3) step();
        check({tag, "_busy_in_drain"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        step();
        check({tag, "_busy_after_drain"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_valid_after_drain"}, 32'(sample_valid), 32'd0);
        check({tag, "_da_idle"}, 32'(DA_out), 32'h1FFF);
        step();
        check({tag, "_done_single"}, 32'(done), 32'd0);
    endtask

    // Monitor: pop and compare each presented sample; idle output must sit at midscale
    always @(negedge CLK) begin
        if (RST_n === 1'b1) begin
            if (sample_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0h with no sample expected", DA_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (DA_out !== exp_v) begin
                        n_fail++;
                        $display("FAIL sample: got %0h expected %0h", DA_out, exp_v);
                    end
                end
            end else begin
                n_chk++;
                if (DA_out !== 14'h1FFF) begin
                    n_fail++;
                    $display("FAIL idle_code: got %0h expected 1fff", DA_out);
                end
            end
        end
    end

    initial begin
        RST_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_fword = '0;
        cfg_amp   = '0;
        cfg_burst = '0;
        start     = 1'b0;
        stop      = 1'b0;
        m_phase   = '0;
        m_act_fw  = '0;
        m_shd_fw  = '0;
        m_amp     = '0;

        // Reset state
        repeat (2) step();
        check("rst_da", 32'(DA_out), 32'h1FFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        RST_n = 1'b1;
        step();

        // 8-sample quarter-period burst: 0, +pk, 0, -pk with pk from LUT[255]=8191 at amp 255
        do_cfg(32'h4000_0000, 8'd255, 16'd8);
        do_start();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(14'h1FFF);
            exp_q.push_back(14'h0020);
            exp_q.push_back(14'h1FFF);
            exp_q.push_back(14'h3FDF);
        end
        for (int j = 0; j < 8; j++) begin
            step();
            if (j == 0) check("t2_busy_run", 32'(busy), 32'd1);
            if (j == 2) check("t2_latency_early", 32'(sample_valid), 32'd0);
            if (j == 3) check("t2_latency_first", 32'(sample_valid), 32'd1);
        end
        drain_check("t2");

        // Continuous burst stopped after 100 cycles
        do_cfg(32'h0123_4567, 8'd200, 16'd0);
        do_start();
        for (int j = 0; j < 100; j++) begin
            if (j == 99) stop = 1'b1;
            model_step(1'b0, '0);
            step();
            stop = 1'b0;
        end
        drain_check("t3");

        // Mid-run frequency change, including a cfg accepted on the wrap cycle itself
        do_cfg(32'h1000_0000, 8'd255, 16'd32);
        do_start();
        for (int j = 0; j < 32; j++) begin
            if (j == 5 || j == 15) begin
                cfg_valid = 1'b1;
                cfg_fword = (j == 5) ? 32'h2000_0000 : 32'h4000_0000;
                cfg_amp   = 8'd255;
                cfg_burst = 16'd32;
            end
            model_step(cfg_valid, cfg_fword);
            step();
            cfg_valid = 1'b0;
        end
        drain_check("t4");

        // Zero amplitude gives midscale with valid asserted
        do_cfg(32'h0800_0000, 8'd0, 16'd6);
        do_start();
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(14'h1FFF);
            step();
        end
        drain_check("t5");

        // start and stop together in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check("t5_startstop_busy", 32'(busy), 32'd0);
            check("t5_startstop_done", 32'(done), 32'd0);
            step();
        end

        // start pulsed during RUN is ignored
        do_cfg(32'h1000_0000, 8'd128, 16'd10);
        do_start();
        for (int j = 0; j < 10; j++) begin
            if (j == 3) start = 1'b1;
            model_step(1'b0, '0);
            step();
            start = 1'b0;
        end
        drain_check("t6");

        // Reset mid-run: outputs go idle with no clock edge
        do_cfg(32'h0400_0000, 8'd255, 16'd0);
        do_start();
        for (int j = 0; j < 20; j++) begin
            model_step(1'b0, '0);
            step();
        end
        #2;
        RST_n = 1'b0;
        #1;
        check("t1_rst_da", 32'(DA_out), 32'h1FFF);
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("t1_rst_valid", 32'(sample_valid), 32'd0);
        check("t1_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) step();
        RST_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check("t1_post_busy", 32'(busy), 32'd0);
            check("t1_post_done", 32'(done), 32'd0);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
